// File: rtl/trigger_pkg.sv
// -----------------------------------------------------------------------------
// trigger_pkg
// Shared definitions for the multi_trigger block: the FSM state encoding, the
// default parameter values, and a small helper to size the cycle counters.
// -----------------------------------------------------------------------------
package trigger_pkg;

  typedef enum logic [1:0] {
    READY  = 2'd0,
    INC    = 2'd1,
    SETTLE = 2'd2,
    BLOCK  = 2'd3
  } state_e;

  localparam int DEF_CHANNELS        = 6;
  localparam int DEF_DEBOUNCE_CYCLES = 10240;
  localparam int DEF_SETTLE_CYCLES   = 16;
  localparam int DEF_REPEAT_CYCLES   = 512000;

  // Largest of three values; used to size a counter that never wraps.
  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/trigger_sync_edge.sv
// -----------------------------------------------------------------------------
// trigger_sync_edge
// One trigger channel: a 2-flop synchronizer for the raw asynchronous level,
// plus the "previous" register used by the top level for rising-edge detect.
//
// Ports:
//   clk        system clock
//   reset_n    asynchronous active-low reset
//   trigger    raw asynchronous trigger level
//   prev_load  when high, prev takes the current synchronized value
//   sync       second synchronizer stage (the clean level)
//   prev       remembered level for edge detection
// -----------------------------------------------------------------------------
module trigger_sync_edge (
  input  logic clk,
  input  logic reset_n,
  input  logic trigger,
  input  logic prev_load,
  output logic sync,
  output logic prev
);

  logic meta_q;
  logic sync_q;
  logic prev_q;
  logic prev_d;

  // prev is frozen while the FSM is busy so that activity during the lockout
  // never looks like a fresh edge once READY is re-entered.
  always_comb begin
    prev_d = prev_q;
    if (prev_load) prev_d = sync_q;
  end

  // NOTE: sequential state uses non-blocking (<=) so every flop samples the
  // pre-edge values; combinational blocks use blocking (=).
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      meta_q <= trigger;
      sync_q <= meta_q;
      prev_q <= prev_d;
    end
  end

  assign sync = sync_q;
  assign prev = prev_q;

endmodule

// File: rtl/multi_trigger.sv
// -----------------------------------------------------------------------------
// multi_trigger
// Multi-channel trigger front end. Rising edges on the synchronized trigger
// inputs produce a one-cycle inc_mask pulse, followed after a settle delay by a
// one-cycle ref_clk pulse, then a debounce lockout during which all trigger
// activity is ignored.
//
// Compile-time option:
//   TRIGGER_REPEAT_EN  when defined, a channel held high in READY re-fires
//                      every REPEAT_CYCLES (auto-repeat).
//
// Ports:
//   clk       system clock
//   reset_n   asynchronous active-low reset
//   trigger   raw asynchronous trigger levels, active high
//   inc_mask  one-cycle pulse, bit i = increment channel i
//   ref_clk   one-cycle output-refresh pulse
//   busy      high in every state except READY
// -----------------------------------------------------------------------------
module multi_trigger
  import trigger_pkg::*;
#(
  parameter int CHANNELS        = DEF_CHANNELS,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int SETTLE_CYCLES   = DEF_SETTLE_CYCLES,
  parameter int REPEAT_CYCLES   = DEF_REPEAT_CYCLES
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [CHANNELS-1:0] trigger,
  output logic [CHANNELS-1:0] inc_mask,
  output logic                ref_clk,
  output logic                busy
);

  localparam int CNT_W =
    $clog2(max3(DEBOUNCE_CYCLES, SETTLE_CYCLES, REPEAT_CYCLES) + 1);
  localparam logic [CNT_W-1:0] SETTLE_LAST   = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] DEBOUNCE_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  state_e                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [CHANNELS-1:0]   inc_mask_q, inc_mask_d;
  logic                  ref_clk_q, ref_clk_d;

  logic [CHANNELS-1:0]   sync;
  logic [CHANNELS-1:0]   prev;
  logic [CHANNELS-1:0]   new_edge;
  logic                  prev_load;

`ifdef TRIGGER_REPEAT_EN
  localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_CYCLES - 1);
  logic [CHANNELS-1:0]   held_q, held_d;
  logic [CNT_W-1:0]      rpt_q, rpt_d;
`endif

  // prev follows sync continuously in READY and is refreshed once more on the
  // final BLOCK cycle, so a level still high at BLOCK exit is not an edge.
  assign prev_load = (state_q == READY) ||
                     ((state_q == BLOCK) && (cnt_q == DEBOUNCE_LAST));

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    trigger_sync_edge u_sync_edge (
      .clk       (clk),
      .reset_n   (reset_n),
      .trigger   (trigger[i]),
      .prev_load (prev_load),
      .sync      (sync[i]),
      .prev      (prev[i])
    );
  end

  assign new_edge = sync & ~prev;

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // through the case leaves a signal unassigned and no latch is inferred.
    state_d    = state_q;
    cnt_d      = cnt_q;
    inc_mask_d = '0;
    ref_clk_d  = 1'b0;
`ifdef TRIGGER_REPEAT_EN
    held_d     = held_q;
    rpt_d      = '0;      // cleared in any state but a counting READY
`endif

    unique case (state_q)
      READY: begin
        if (new_edge != '0) begin
          inc_mask_d = new_edge;
          cnt_d      = '0;
          state_d    = INC;
`ifdef TRIGGER_REPEAT_EN
          held_d     = new_edge;
`endif
        end
`ifdef TRIGGER_REPEAT_EN
        else if ((sync & held_q) != '0) begin
          if (rpt_q == REPEAT_LAST) begin
            inc_mask_d = sync & held_q;
            held_d     = sync & held_q;
            cnt_d      = '0;
            state_d    = INC;
          end else begin
            rpt_d = rpt_q + 1'b1;
          end
        end
`endif
      end

      // inc_mask_q was loaded on entry, so it is high for exactly this cycle.
      INC: state_d = SETTLE;

      SETTLE: begin
        if (cnt_q == SETTLE_LAST) begin
          ref_clk_d = 1'b1;
          cnt_d     = '0;
          state_d   = BLOCK;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      BLOCK: begin
        if (cnt_q == DEBOUNCE_LAST) begin
          cnt_d   = '0;
          state_d = READY;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      default: state_d = READY;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= READY;
      cnt_q      <= '0;
      inc_mask_q <= '0;
      ref_clk_q  <= 1'b0;
`ifdef TRIGGER_REPEAT_EN
      held_q     <= '0;
      rpt_q      <= '0;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      inc_mask_q <= inc_mask_d;
      ref_clk_q  <= ref_clk_d;
`ifdef TRIGGER_REPEAT_EN
      held_q     <= held_d;
      rpt_q      <= rpt_d;
`endif
    end
  end

  assign inc_mask = inc_mask_q;
  assign ref_clk  = ref_clk_q;
  assign busy     = (state_q != READY);

endmodule

// File: doc/multi_trigger.md
MULTI_TRIGGER -- requirements
Module: multi_trigger

Interface
REQ-001 Parameter CHANNELS, default 6, number of independent trigger inputs; legal range 1..16.
REQ-002 Parameter DEBOUNCE_CYCLES, default 10240, lockout length in clk cycles after each refresh pulse; must be >= 1.
REQ-003 Parameter SETTLE_CYCLES, default 16, wait between inc pulse and refresh pulse, for carry ripple; must be >= 1.
REQ-004 Parameter REPEAT_CYCLES, default 512000, hold time before auto-repeat; used only when TRIGGER_REPEAT_EN is defined.
REQ-005 clk  input  1  system clock; all state is updated on its rising edge.
REQ-006 reset_n  input  1  reset, asynchronous, active-low.
REQ-007 trigger  input  CHANNELS  raw asynchronous trigger levels; high means active.
REQ-008 inc_mask  output  CHANNELS  one-cycle pulse; bit i high means increment channel i.
REQ-009 ref_clk  output  1  one-cycle output-refresh pulse.
REQ-010 busy  output  1  high in every state except READY.

Function
REQ-011 Each trigger bit SHALL pass a 2-flop synchronizer; "sync" means the second-stage value.
REQ-012 The FSM SHALL have four states: READY, INC, SETTLE, BLOCK.
REQ-013 READY behaviour:
- prev <= sync every cycle.
- new = sync & ~prev.
- If new != 0: inc_mask <= new, counter <= 0, next state INC.
REQ-014 INC SHALL last exactly one cycle, with inc_mask held at the captured value, then go to SETTLE; inc_mask SHALL be 0 in every other state.
REQ-015 SETTLE:
- Counter increments from 0.
- When counter == SETTLE_CYCLES-1: ref_clk high for exactly one cycle, counter <= 0, next state BLOCK.
- Rising edge of ref_clk therefore comes SETTLE_CYCLES+1 cycles after the rising edge of inc_mask.
REQ-016 BLOCK:
- Counter increments.
- When counter == DEBOUNCE_CYCLES-1: prev <= sync, next state READY.
REQ-017 All trigger activity during INC, SETTLE and BLOCK SHALL be ignored.
- A level still high at BLOCK exit SHALL NOT trigger.
- A rise-and-fall entirely inside these states SHALL be lost.
REQ-018 Simultaneous rising edges on several channels in one READY cycle SHALL all appear in the same inc_mask pulse.
REQ-019 Counter width SHALL be $clog2(max(DEBOUNCE_CYCLES, SETTLE_CYCLES, REPEAT_CYCLES)+1); the counter SHALL never wrap.
REQ-020 Falling edges SHALL never produce inc_mask.

Reset
REQ-021 While reset_n is low, the block SHALL hold:
- inc_mask = 0, ref_clk = 0, busy = 0;
- state READY;
- counter, prev, synchronizer flops and repeat counter all 0.
REQ-022 Reset asserted mid-INC, mid-SETTLE or mid-BLOCK SHALL abort immediately with no pending ref_clk.
REQ-023 A trigger already high when reset_n deasserts SHALL produce one inc_mask pulse, because prev = 0.

Configuration
REQ-024 Macro TRIGGER_REPEAT_EN defined: auto-repeat is compiled in.
- On each accepted trigger, held_mask <= the captured mask.
- In READY, a repeat counter counts while (sync & held_mask) != 0 and new == 0.
- When the repeat counter reaches REPEAT_CYCLES-1: inc_mask <= sync & held_mask, then the normal INC/SETTLE/BLOCK sequence follows.
- The repeat counter clears when leaving READY or when (sync & held_mask) == 0.
- A new edge has priority over a repeat and replaces held_mask.
REQ-025 Macro not defined: held_mask, the repeat counter and REPEAT_CYCLES logic are absent; a held input triggers exactly once.

Structure
REQ-026 Package trigger_pkg SHALL hold the FSM state enum (READY, INC, SETTLE, BLOCK) and the default parameter constants.
REQ-027 Sub-module trigger_sync_edge (per channel: synchronizer plus prev register) SHALL be instantiated CHANNELS times by generate.

Verification
REQ-028 Directed scenarios, all with DEBOUNCE_CYCLES=20 and SETTLE_CYCLES=4:
- Reset test: assert reset_n low during SETTLE -> ref_clk never pulses; all outputs 0 within the same cycle.
- Single-channel test: ch0 rises -> inc_mask=0x01 for 1 cycle exactly 3 cycles later (2-cycle synchronizer plus the READY capture cycle); ref_clk 5 cycles after inc_mask; busy high for 1+4+20 cycles.
- Simultaneous test: ch0 and ch3 rise in the same cycle -> a single inc_mask=0x09.
- Blocked-edge test: ch1 pulses during BLOCK, then stays high past BLOCK exit -> no inc_mask; after a fall and a rise in READY -> inc_mask=0x02.
- Bounce test: ch2 toggles every 3 cycles for 60 cycles -> exactly one inc_mask per completed READY window, never two within 25 cycles.
- TRIGGER_REPEAT_EN test, REPEAT_CYCLES=50: ch0 held high -> inc_mask=0x01 at the initial edge, then every 1+4+20+50 cycles; stops once ch0 drops.
